// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_port_arbiter                                                 |
// | Function : N-channel round-robin arbiter in front of a single memory port  |
// |            with registered strobes, one-cycle ack and optional timeout.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic [NUM_CH-1:0]        iReq,
    input  logic [NUM_CH-1:0]        iWe,
    input  logic [NUM_CH*ADDR_W-1:0] iAddr,
    input  logic [NUM_CH*DATA_W-1:0] iWData,
    output logic [NUM_CH-1:0]        oGnt,
    output logic [NUM_CH-1:0]        oAck,
    output logic [DATA_W-1:0]        oRData,
    output logic                     oErr,
    output logic [ADDR_W-1:0]        oMemAddr,
    output logic [DATA_W-1:0]        oMemData,
    output logic                     oMemRead,
    output logic                     oMemWrite,
    input  logic [DATA_W-1:0]        iMemData,
    input  logic                     iMemRdy
);

    localparam int c_ptr_w = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [NUM_CH-1:0]  c_one      = NUM_CH'(1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    function automatic int wrap_idx(input int base, input int off);
        return (base + off) % NUM_CH;
    endfunction

    logic [1:0]         r_state, w_state_nxt;
    logic [c_ptr_w-1:0] r_ptr, r_ch, w_ptr_nxt, w_ch_nxt, w_sel, w_ptr_inc;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic [NUM_CH-1:0]  r_gnt, r_ack, w_gnt_nxt, w_ack_nxt;
    logic [DATA_W-1:0]  r_rdata, w_rdata_nxt, r_mem_data, w_mem_data_nxt, w_sel_data;
    logic [ADDR_W-1:0]  r_mem_addr, w_mem_addr_nxt, w_sel_addr;
    logic               r_err, w_err_nxt, r_mem_rd, w_mem_rd_nxt, r_mem_wr, w_mem_wr_nxt;
    logic               w_any, w_sel_we, w_expire;

    // First requester at or after the pointer, wrapping; served channel moves to lowest priority.
    always_comb begin
        w_any      = 1'b0;
        w_sel      = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        w_sel_we   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!w_any && iReq[wrap_idx(int'(r_ptr), i)]) begin
                w_any      = 1'b1;
                w_sel      = c_ptr_w'(wrap_idx(int'(r_ptr), i));
                w_sel_addr = iAddr[wrap_idx(int'(r_ptr), i)*ADDR_W +: ADDR_W];
                w_sel_data = iWData[wrap_idx(int'(r_ptr), i)*DATA_W +: DATA_W];
                w_sel_we   = iWe[wrap_idx(int'(r_ptr), i)];
            end
        end
    end

    assign w_ptr_inc = c_ptr_w'(wrap_idx(int'(r_ch), 1));
    assign w_expire  = (TIMEOUT > 0) && (r_cnt == c_cnt_last);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state    <= c_st_idle;
            r_ptr      <= '0;
            r_ch       <= '0;
            r_cnt      <= '0;
            r_gnt      <= '0;
            r_ack      <= '0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_ch       <= w_ch_nxt;
            r_cnt      <= w_cnt_nxt;
            r_gnt      <= w_gnt_nxt;
            r_ack      <= w_ack_nxt;
            r_err      <= w_err_nxt;
            r_rdata    <= w_rdata_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_data <= w_mem_data_nxt;
            r_mem_rd   <= w_mem_rd_nxt;
            r_mem_wr   <= w_mem_wr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_any) w_state_nxt = c_st_busy;
            c_st_busy: if (iMemRdy || w_expire) w_state_nxt = c_st_resp;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // Next values for every registered output; iMemRdy beats a coincident timeout.
    always_comb begin
        w_ptr_nxt      = r_ptr;
        w_ch_nxt       = r_ch;
        w_cnt_nxt      = r_cnt;
        w_gnt_nxt      = r_gnt;
        w_ack_nxt      = r_ack;
        w_err_nxt      = r_err;
        w_rdata_nxt    = r_rdata;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_data_nxt = r_mem_data;
        w_mem_rd_nxt   = r_mem_rd;
        w_mem_wr_nxt   = r_mem_wr;
        case (r_state)
            c_st_idle: begin
                if (w_any) begin
                    w_ch_nxt       = w_sel;
                    w_gnt_nxt      = c_one << w_sel;
                    w_mem_addr_nxt = w_sel_addr;
                    w_mem_data_nxt = w_sel_data;
                    w_mem_rd_nxt   = ~w_sel_we;
                    w_mem_wr_nxt   = w_sel_we;
                    w_cnt_nxt      = '0;
                end
            end
            c_st_busy: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (iMemRdy) begin
                    if (r_mem_rd) w_rdata_nxt = iMemData;
                    w_ack_nxt    = c_one << r_ch;
                    w_mem_rd_nxt = 1'b0;
                    w_mem_wr_nxt = 1'b0;
                    w_ptr_nxt    = w_ptr_inc;
                end else if (w_expire) begin
                    w_rdata_nxt  = '0;
                    w_ack_nxt    = c_one << r_ch;
                    w_err_nxt    = 1'b1;
                    w_mem_rd_nxt = 1'b0;
                    w_mem_wr_nxt = 1'b0;
                    w_ptr_nxt    = w_ptr_inc;
                end
            end
            default: begin
                w_gnt_nxt = '0;
                w_ack_nxt = '0;
                w_err_nxt = 1'b0;
                w_cnt_nxt = '0;
            end
        endcase
    end

    assign oGnt      = r_gnt;
    assign oAck      = r_ack;
    assign oErr      = r_err;
    assign oRData    = r_rdata;
    assign oMemAddr  = r_mem_addr;
    assign oMemData  = r_mem_data;
    assign oMemRead  = r_mem_rd;
    assign oMemWrite = r_mem_wr;

endmodule
`default_nettype wire
